// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: capture FSM states, glyph table and frame entry layout.
package seg7_pkg;

  typedef enum logic [1:0] {StCollect, StCheck, StOutput} state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high {a,b,c,d,e,f,g,dp} glyphs with dp=0; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef struct packed {
    logic       bad;
    logic       dp;
    logic [3:0] nib;
  } entry_t;

  function automatic logic [7:0] glyph_of(input logic [3:0] nib);
    return GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to {bad, dp, nibble} decoder.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_INV = 1'b0
) (
  input  logic [7:0] seg_i,
  output entry_t     entry_o
);

  logic [7:0] seg_act;

  assign seg_act = SEG_INV ? ~seg_i : seg_i;

  // The dp bit never takes part in glyph matching.
  always_comb begin
    entry_o = '{bad: 1'b1, dp: seg_act[0], nib: 4'h0};
    for (int i = 0; i < 16; i++) begin
      if (seg_act[7:1] == GLYPH[i][7:1]) begin
        entry_o.bad = 1'b0;
        entry_o.nib = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 7-seg bus, rebuilds one frame of digits, optionally confirms it
// against a second identical frame and offers it on a valid/ready interface.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG    = 8,
  parameter bit          CONFIRM = 1'b1,
  parameter bit          SEG_INV = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_i,
  input  logic [NDIG-1:0]   dig_sel_i,
  input  logic              seg_stb_i,
  output logic [4*NDIG-1:0] val_o,
  output logic [NDIG-1:0]   dp_o,
  output logic [NDIG-1:0]   bad_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sel_err_o
);

  entry_t               entry;
  state_e               state_q, state_d;
  entry_t [NDIG-1:0]    buf_q, buf_d;
  logic   [NDIG-1:0]    seen_q, seen_d, seen_nxt;
  logic                 mis_q, mis_d, mis_nxt;
  logic                 valid_q, valid_d;
  logic                 sel_err_q, sel_err_d;
  logic                 sel_ok, wr, hs, diff;

  seg7_decode #(
    .SEG_INV(SEG_INV)
  ) u_decode (
    .seg_i  (seg_i),
    .entry_o(entry)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    seen_d    = seen_q;
    mis_d     = mis_q;
    sel_ok    = $onehot(dig_sel_i);
    hs        = valid_q && ready_i;
    // Strobes are dropped while a frame is on offer.
    wr        = seg_stb_i && sel_ok && (state_q != StOutput);
    sel_err_d = seg_stb_i && !sel_ok;
    valid_d   = (state_q == StOutput) && !hs;
    seen_nxt  = seen_q | dig_sel_i;
    diff      = 1'b0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (dig_sel_i[k] && (buf_q[k] != entry)) diff = 1'b1;
    end
    mis_nxt = mis_q | ((state_q == StCheck) && diff);

    unique case (state_q)
      StCollect, StCheck: begin
        if (wr) begin
          for (int k = 0; k < int'(NDIG); k++) begin
            if (dig_sel_i[k]) buf_d[k] = entry;
          end
          mis_d = mis_nxt;
          if (seen_nxt == '1) begin
            seen_d = '0;
            if (state_q == StCollect) begin
              state_d = CONFIRM ? StCheck : StOutput;
            end else if (mis_nxt) begin
              mis_d = 1'b0;
            end else begin
              state_d = StOutput;
            end
          end else begin
            seen_d = seen_nxt;
          end
        end
      end
      StOutput: begin
        if (hs) begin
          seen_d  = '0;
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      buf_q     <= '0;
      seen_q    <= '0;
      mis_q     <= 1'b0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      seen_q    <= seen_d;
      mis_q     <= mis_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    val_o = '0;
    dp_o  = '0;
    bad_o = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      val_o[4*k +: 4] = buf_q[k].nib;
      dp_o[k]         = buf_q[k].dp;
      bad_o[k]        = buf_q[k].bad;
    end
  end

  assign valid_o   = valid_q;
  assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: one CONFIRM=0 and one CONFIRM=1 instance on a shared bus,
// vector table, directed corner sequences and random traffic against a frame-level model.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        stb;
  logic        ready;

  logic [15:0] val_w    [2];
  logic [3:0]  dp_w     [2];
  logic [3:0]  bad_w    [2];
  logic        valid_w  [2];
  logic        selerr_w [2];

  seg7_capture #(.NDIG(4), .CONFIRM(1'b0), .SEG_INV(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seg_i(seg), .dig_sel_i(dig), .seg_stb_i(stb),
    .val_o(val_w[0]), .dp_o(dp_w[0]), .bad_o(bad_w[0]), .valid_o(valid_w[0]),
    .ready_i(ready), .sel_err_o(selerr_w[0])
  );

  seg7_capture #(.NDIG(4), .CONFIRM(1'b1), .SEG_INV(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_i(seg), .dig_sel_i(dig), .seg_stb_i(stb),
    .val_o(val_w[1]), .dp_o(dp_w[1]), .bad_o(bad_w[1]), .valid_o(valid_w[1]),
    .ready_i(ready), .sel_err_o(selerr_w[1])
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Frame-level model per instance: phase 0 collecting, 1 confirming, 2 offering.
  int         m_phase [2];
  logic [3:0] m_seen  [2];
  logic [5:0] m_buf   [2][4];
  bit         m_mis   [2];
  bit         m_valid [2];
  bit         m_selerr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pats;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  bad;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dec(input logic [7:0] s);
    for (int i = 0; i < 16; i++) begin
      if (s[7:1] == glyph[i][7:1]) return {1'b0, s[0], 4'(i)};
    end
    return {1'b1, s[0], 4'h0};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c] = 0;
      m_seen[c]  = 4'h0;
      m_mis[c]   = 1'b0;
      m_valid[c] = 1'b0;
      for (int k = 0; k < 4; k++) m_buf[c][k] = 6'h0;
    end
    m_selerr = 1'b0;
  endtask

  task automatic model_edge();
    bit         ok, hs, nv;
    int         k;
    logic [5:0] e;
    ok = stb && ($countones(dig) == 1);
    k  = 0;
    for (int i = 0; i < 4; i++) if (dig[i]) k = i;
    e = dec(seg);
    for (int c = 0; c < 2; c++) begin
      hs = m_valid[c] && ready;
      nv = (m_phase[c] == 2) && !hs;
      if (m_phase[c] == 2) begin
        if (hs) begin
          m_phase[c] = 0;
          m_seen[c]  = 4'h0;
        end
      end else if (ok) begin
        if (m_phase[c] == 1 && m_buf[c][k] != e) m_mis[c] = 1'b1;
        m_buf[c][k]  = e;
        m_seen[c][k] = 1'b1;
        if (m_seen[c] == 4'hF) begin
          m_seen[c] = 4'h0;
          if (m_phase[c] == 0) m_phase[c] = (c == 1) ? 1 : 2;
          else if (m_mis[c]) m_mis[c] = 1'b0;
          else m_phase[c] = 2;
        end
      end
      m_valid[c] = nv;
    end
    m_selerr = stb && ($countones(dig) != 1);
  endtask

  task automatic compare_all();
    logic [15:0] ev;
    logic [3:0]  ed, eb;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("valid%0d", c), valid_w[c], m_valid[c]);
      check($sformatf("sel_err%0d", c), selerr_w[c], m_selerr);
      if (m_valid[c]) begin
        for (int k = 0; k < 4; k++) begin
          ev[4*k +: 4] = m_buf[c][k][3:0];
          ed[k]        = m_buf[c][k][4];
          eb[k]        = m_buf[c][k][5];
        end
        check($sformatf("val%0d", c), val_w[c], ev);
        check($sformatf("dp%0d", c), dp_w[c], ed);
        check($sformatf("bad%0d", c), bad_w[c], eb);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic strobe(input int d, input logic [7:0] s);
    seg = s;
    dig = 4'(1 << d);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    dig = 4'h0;
  endtask

  task automatic frame(input logic [31:0] pats);
    for (int d = 0; d < 4; d++) strobe(d, pats[8*d +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s_val%0d", tag, c), val_w[c], 16'h0);
      check($sformatf("%s_dp%0d", tag, c), dp_w[c], 4'h0);
      check($sformatf("%s_bad%0d", tag, c), bad_w[c], 4'h0);
      check($sformatf("%s_valid%0d", tag, c), valid_w[c], 1'b0);
      check($sformatf("%s_selerr%0d", tag, c), selerr_w[c], 1'b0);
    end
  endtask

  initial begin
    logic [31:0] pat_a, pat_b, p;
    logic [3:0]  bad_sel [5];
    int          r, d;

    vecs[0] = '{32'hF2DA60FC, 16'h3210, 4'h0, 4'h0};
    vecs[1] = '{32'hE0BEB666, 16'h7654, 4'h0, 4'h0};
    vecs[2] = '{32'h3EEEF6FE, 16'hBA98, 4'h0, 4'h0};
    vecs[3] = '{32'h8E9E7A9C, 16'hFEDC, 4'h0, 4'h0};
    vecs[4] = '{32'h00FD018F, 16'h000F, 4'b0111, 4'b1010};
    bad_sel = '{4'h0, 4'h3, 4'h5, 4'hC, 4'hF};

    rst_n = 1'b0; seg = 8'h0; dig = 4'h0; stb = 1'b0; ready = 1'b1;
    model_reset();
    #2 check_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Vector table: each frame must appear one cycle after its last strobe on dut0.
    for (int i = 0; i < 5; i++) begin
      frame(vecs[i].pats);
      check($sformatf("tbl%0d_lat", i), valid_w[0], 1'b0);
      tick();
      check($sformatf("tbl%0d_valid", i), valid_w[0], 1'b1);
      check($sformatf("tbl%0d_val", i), val_w[0], vecs[i].val);
      check($sformatf("tbl%0d_dp", i), dp_w[0], vecs[i].dp);
      check($sformatf("tbl%0d_bad", i), bad_w[0], vecs[i].bad);
      tick();
      check($sformatf("tbl%0d_drop", i), valid_w[0], 1'b0);
    end

    // Confirmation: two identical frames, then a changed digit 2 needing a repeat.
    do_reset();
    pat_a = vecs[0].pats;
    pat_b = 32'hF26660FC;
    frame(pat_a);
    tick();
    check("cf_first", valid_w[1], 1'b0);
    frame(pat_a);
    check("cf_lat", valid_w[1], 1'b0);
    tick();
    check("cf_valid", valid_w[1], 1'b1);
    check("cf_val", val_w[1], 16'h3210);
    tick();
    frame(pat_a);
    frame(pat_b);
    tick();
    check("cf_mis1", valid_w[1], 1'b0);
    tick();
    check("cf_mis2", valid_w[1], 1'b0);
    frame(pat_b);
    tick();
    check("cf_third", valid_w[1], 1'b1);
    check("cf_third_val", val_w[1], 16'h3410);
    tick();

    // Non-one-hot selects: error pulse, no effect on frame progress.
    do_reset();
    strobe(0, 8'hFC);
    strobe(1, 8'h60);
    seg = 8'hDA; dig = 4'b0101; stb = 1'b1;
    tick();
    check("se_pulse", selerr_w[0], 1'b1);
    seg = 8'hF2; dig = 4'b1100;
    tick();
    check("se_pulse2", selerr_w[0], 1'b1);
    stb = 1'b0; dig = 4'h0;
    tick();
    check("se_clear", selerr_w[0], 1'b0);
    check("se_noframe", valid_w[0], 1'b0);
    strobe(2, 8'hDA);
    tick();
    check("se_partial", valid_w[0], 1'b0);
    strobe(3, 8'hF2);
    tick();
    check("se_frame", valid_w[0], 1'b1);
    check("se_val", val_w[0], 16'h3210);
    tick();

    // Back-pressure: frame held while strobes keep arriving.
    do_reset();
    ready = 1'b0;
    frame(vecs[1].pats);
    tick();
    for (int i = 0; i < 20; i++) begin
      seg = glyph[$urandom_range(0, 15)];
      dig = 4'(1 << $urandom_range(0, 3));
      stb = 1'b1;
      tick();
      check("bp_valid", valid_w[0], 1'b1);
      check("bp_val", val_w[0], 16'h7654);
    end
    stb = 1'b0; dig = 4'h0;
    ready = 1'b1;
    tick();
    check("bp_release", valid_w[0], 1'b0);
    frame(vecs[0].pats);
    tick();
    check("bp_restart", valid_w[0], 1'b1);
    check("bp_restart_val", val_w[0], 16'h3210);
    tick();

    // Reset in the middle of confirmation discards the partial frame.
    do_reset();
    frame(pat_a);
    strobe(0, pat_a[7:0]);
    strobe(1, pat_a[15:8]);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_zero("mid_rst");
    #2 rst_n = 1'b1;
    frame(pat_a);
    tick();
    check("rst_first", valid_w[1], 1'b0);
    frame(pat_a);
    tick();
    check("rst_second", valid_w[1], 1'b1);
    tick();

    // Random traffic with slowly changing display content.
    do_reset();
    p = vecs[2].pats;
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 7) == 0) p[8*d +: 8] = 8'($urandom);
        else p[8*d +: 8] = glyph[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
      end
      stb = 1'b0;
      dig = 4'h0;
      if (r < 6) begin
        stb = 1'b1;
        dig = 4'(1 << d);
        seg = p[8*d +: 8];
      end else if (r == 6) begin
        stb = 1'b1;
        dig = bad_sel[$urandom_range(0, 4)];
        seg = 8'($urandom);
      end
      tick();
    end
    stb = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
